// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit period, data width.
package uart_pkg;

   localparam int CLKS_PER_BIT_DEF = 868;   // 100 MHz / 115200
   localparam int DATA_W           = 8;

   // State encoding shared by the UART receive and transmit ends
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } uart_state_e;

   // Offset from the start edge to the centre of a bit
   function automatic logic [15:0] half_bit(input int cpb);
      return 16'((cpb - 1) / 2);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; both flops reset
// to RST_VAL so an idle-high line never looks like an edge coming out of reset.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage resync of the asynchronous input
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples every bit at its centre, delivers each byte
// with a one-cycle valid strobe.
// Optional feature macro: UART_RX_FRAME_ERR_EN -- checks the stop bit, flags
// o_frame_err with the byte and parks in BREAK until the line returns high.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_rx,
   output logic [DATA_W-1:0] o_data_byte,
   output logic              o_data_valid,
   output logic              o_active,
   output logic              o_frame_err
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = half_bit(CLKS_PER_BIT);

   logic              rx_s;
   uart_state_e       state_q;
   logic [15:0]       cnt_q;
   logic [15:0]       cnt_d;
   logic [2:0]        idx_q;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] byte_q;
   logic              valid_q;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (i_rx),
      .sync_o  (rx_s)
   );

   // Free-running increment shared by every counting state
   always_comb begin
      cnt_d = cnt_q + 16'd1;
   end

`ifdef UART_RX_FRAME_ERR_EN
   logic ferr_q;
`endif

   // Receive FSM with registered byte, valid and frame-error outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q  <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         ferr_q  <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               idx_q <= '0;
               if (!rx_s) begin
                  state_q <= ST_START;
                  // The edge that detects the low level is already one
                  // cycle into the start bit, so the qualify check lands
                  // exactly half a bit after entering START.
                  cnt_q   <= 16'd1;
               end
            end
            ST_START: begin
               if (cnt_q == HALF) begin
                  cnt_q   <= '0;
                  state_q <= rx_s ? ST_IDLE : ST_DATA;   // high = glitch
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DATA: begin
               if (cnt_q == LAST) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= rx_s;                 // LSB first
                  if (idx_q == 3'd7) state_q <= ST_STOP;
                  else               idx_q   <= idx_q + 3'd1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_STOP: begin
               if (cnt_q == LAST) begin
                  cnt_q   <= '0;
                  byte_q  <= shift_q;
                  valid_q <= 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
                  ferr_q  <= !rx_s;
                  state_q <= rx_s ? ST_IDLE : ST_BREAK;
`else
                  state_q <= ST_IDLE;
`endif
               end else begin
                  cnt_q <= cnt_d;
               end
            end
`ifdef UART_RX_FRAME_ERR_EN
            ST_BREAK: begin
               // Held-low line: ignore it until it returns to idle
               if (rx_s) state_q <= ST_IDLE;
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_data_byte  = byte_q;
   assign o_data_valid = valid_q;
   assign o_active     = (state_q != ST_IDLE);
`ifdef UART_RX_FRAME_ERR_EN
   assign o_frame_err  = ferr_q;
`else
   assign o_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16. Honours
// UART_RX_FRAME_ERR_EN for the stop-bit / break expectations.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int HALF = (CPB - 1) / 2;
   // Edge of the valid cycle relative to t0: 2 sync + half + 9 bits
   localparam int LAT  = 2 + HALF + 9 * CPB;
`ifdef UART_RX_FRAME_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_rx = 1'b1;
   logic [7:0] o_data_byte;
   logic       o_data_valid;
   logic       o_active;
   logic       o_frame_err;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_rx         (i_rx),
      .o_data_byte  (o_data_byte),
      .o_data_valid (o_data_valid),
      .o_active     (o_active),
      .o_frame_err  (o_frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [7:0] b;
      logic       fe;
   } ev_t;

   ev_t got[$];
   ev_t exp_q[$];
   ev_t mon_e;
   int  checks = 0;
   int  failures = 0;
   int  orphan_fe = 0;

   // Record every delivered byte with the edge number that raised it
   always @(negedge clk) begin
      if (o_data_valid) begin
         mon_e.t  = cyc;
         mon_e.b  = o_data_byte;
         mon_e.fe = o_frame_err;
         got.push_back(mon_e);
      end
      if (o_frame_err && !o_data_valid) orphan_fe++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serial frame: start, 8 data LSB first, stop; line left at stop level
   task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
      t0 = cyc + 1;
      i_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         i_rx = d[i];
         tick(CPB);
      end
      i_rx = stop;
      tick(CPB);
   endtask

   task automatic push_exp(input int t, input logic [7:0] b, input logic fe);
      ev_t e;
      e.t = t; e.b = b; e.fe = fe;
      exp_q.push_back(e);
   endtask

   task automatic compare(input string tag);
      int n;
      tick(2);
      chk($sformatf("%s.count", tag), got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s[%0d].time", tag, i), got[i].t, exp_q[i].t);
         chk($sformatf("%s[%0d].byte", tag, i), {24'd0, got[i].b}, {24'd0, exp_q[i].b});
         chk($sformatf("%s[%0d].ferr", tag, i), {31'd0, got[i].fe}, {31'd0, exp_q[i].fe});
      end
      got.delete();
      exp_q.delete();
   endtask

   typedef struct {
      logic [7:0] data;
      int         gap;
      logic [7:0] exp_b;
      logic       exp_fe;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int t0;
      logic [7:0] d;

      tbl[0] = '{8'hA5, 20, 8'hA5, 1'b0};
      tbl[1] = '{8'h00, 10, 8'h00, 1'b0};
      tbl[2] = '{8'hFF,  0, 8'hFF, 1'b0};
      tbl[3] = '{8'h55,  0, 8'h55, 1'b0};
      tbl[4] = '{8'h3C,  5, 8'h3C, 1'b0};
      tbl[5] = '{8'h12, 30, 8'h12, 1'b0};

      // Reset state
      rst = 1'b1;
      i_rx = 1'b1;
      tick(3);
      chk("rst.byte", {24'd0, o_data_byte}, 32'h00);
      chk("rst.valid", {31'd0, o_data_valid}, 32'd0);
      chk("rst.active", {31'd0, o_active}, 32'd0);
      chk("rst.ferr", {31'd0, o_frame_err}, 32'd0);
      rst = 1'b0;
      tick(5);

      // Table vectors: single frames and a back-to-back run (00, FF, 55)
      for (int i = 0; i < 6; i++) begin
         tick(tbl[i].gap);
         send_frame(tbl[i].data, 1'b1, t0);
         push_exp(t0 + LAT, tbl[i].exp_b, tbl[i].exp_fe);
      end
      if (got.size() >= 4) begin
         chk("b2b.spacing01", got[2].t - got[1].t, 32'd160);
         chk("b2b.spacing12", got[3].t - got[2].t, 32'd160);
      end
      compare("table");

      // Randomised frames with random idle gaps (including none)
      for (int i = 0; i < 20; i++) begin
         tick($urandom_range(0, 40));
         d = 8'($urandom_range(0, 255));
         send_frame(d, 1'b1, t0);
         push_exp(t0 + LAT, d, 1'b0);
      end
      compare("rand");

      // Glitch shorter than half a bit
      tick(10);
      i_rx = 1'b0;
      tick(5);
      i_rx = 1'b1;
      chk("glitch.active_hi", {31'd0, o_active}, 32'd1);
      tick(30);
      chk("glitch.active_lo", {31'd0, o_active}, 32'd0);
      chk("glitch.no_valid", got.size(), 32'd0);
      send_frame(8'h3C, 1'b1, t0);
      push_exp(t0 + LAT, 8'h3C, 1'b0);
      compare("post_glitch");

      // Reset in the middle of data bit 4
      tick(10);
      i_rx = 1'b0;
      tick(CPB);
      d = 8'hE7;
      for (int i = 0; i < 4; i++) begin
         i_rx = d[i];
         tick(CPB);
      end
      i_rx = d[4];
      tick(CPB / 2);
      rst = 1'b1;
      tick(1);
      chk("midrst.byte", {24'd0, o_data_byte}, 32'h00);
      chk("midrst.valid", {31'd0, o_data_valid}, 32'd0);
      chk("midrst.active", {31'd0, o_active}, 32'd0);
      chk("midrst.ferr", {31'd0, o_frame_err}, 32'd0);
      i_rx = 1'b1;
      rst = 1'b0;
      tick(200);
      chk("midrst.no_valid", got.size(), 32'd0);
      send_frame(8'h12, 1'b1, t0);
      push_exp(t0 + LAT, 8'h12, 1'b0);
      compare("post_rst");

      // Low stop bit followed by a held-low line
      tick(10);
      send_frame(8'h81, 1'b0, t0);
      tick(400);
      if (FE_EN) chk("break.active_held", {31'd0, o_active}, 32'd1);
      i_rx = 1'b1;
      tick(10);
      if (FE_EN) begin
         chk("break.active_rel", {31'd0, o_active}, 32'd0);
         push_exp(t0 + LAT, 8'h81, 1'b1);
         compare("break");
      end else begin
         tick(200);
         chk("hold.min_count", {31'd0, got.size() >= 3}, 32'd1);
         if (got.size() >= 3) begin
            chk("hold[0].time", got[0].t, t0 + LAT);
            chk("hold[0].byte", {24'd0, got[0].b}, 32'h81);
            chk("hold[0].ferr", {31'd0, got[0].fe}, 32'd0);
            chk("hold[1].byte", {24'd0, got[1].b}, 32'h00);
            chk("hold[2].byte", {24'd0, got[2].b}, 32'h00);
         end
         got.delete();
      end

      // Line is clean again: one more frame
      tick(50);
      send_frame(8'h5A, 1'b1, t0);
      push_exp(t0 + LAT, 8'h5A, 1'b0);
      compare("final");

      chk("ferr_without_valid", orphan_fe, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
